// File: rtl/adder_pkg.sv
// Shared types for the adder/accumulator datapath: operation modes and the
// stage-1 operand register layout.
package adder_pkg;

    // Widest operand the stage-1 struct can carry; narrower operands are
    // zero-extended into it.
    localparam int unsigned MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        MODE_ADD  = 2'd0,
        MODE_SUB  = 2'd1,
        MODE_ACC  = 2'd2,
        MODE_LOAD = 2'd3
    } mode_e;

    typedef struct packed {
        mode_e                mode;
        logic [MAX_WIDTH-1:0] a;
        logic [MAX_WIDTH-1:0] b;
    } stage1_t;

endpackage

// File: rtl/adder_accumulator_if.sv
// Operand/result handshake bundle between producer, adder_accumulator and
// consumer. The master side drives operands and ready_i; the slave is the block.
interface adder_accumulator_if #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned ACC_WIDTH = 8
);
    import adder_pkg::*;

    logic                 valid_i;
    logic                 ready_o;
    mode_e                mode_i;
    logic [WIDTH-1:0]     number_1;
    logic [WIDTH-1:0]     number_2;
    logic                 valid_o;
    logic                 ready_i;
    logic [ACC_WIDTH-1:0] result;
    logic                 flag_o;

    modport master (
        output valid_i, mode_i, number_1, number_2, ready_i,
        input  ready_o, valid_o, result, flag_o
    );

    modport slave (
        input  valid_i, mode_i, number_1, number_2, ready_i,
        output ready_o, valid_o, result, flag_o
    );

endinterface

// File: rtl/adder_core.sv
// Combinational arithmetic for one operation: ADD, SUB (with borrow flag),
// saturating ACC and LOAD. Produces the result, status flag and next acc.
module adder_core
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned ACC_WIDTH = 8
) (
    input  mode_e                mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [ACC_WIDTH-1:0] acc,
    output logic [ACC_WIDTH-1:0] result,
    output logic                 flag,
    output logic [ACC_WIDTH-1:0] acc_next
);

    logic [ACC_WIDTH-1:0] sum_ab;
    logic [WIDTH:0]       diff;
    // One extra bit so the carry out of acc + a + b marks saturation.
    logic [ACC_WIDTH:0]   acc_sum;

    // Decode the mode into result, flag and the accumulator update.
    always_comb begin
        sum_ab   = ACC_WIDTH'(a) + ACC_WIDTH'(b);
        diff     = {1'b0, a} - {1'b0, b};
        acc_sum  = {1'b0, acc} + (ACC_WIDTH + 1)'(sum_ab);
        result   = '0;
        flag     = 1'b0;
        acc_next = acc;
        unique case (mode)
            MODE_ADD: begin
                result = sum_ab;
            end
            MODE_SUB: begin
                result = ACC_WIDTH'(diff);
                flag   = diff[WIDTH];
            end
            MODE_ACC: begin
                if (acc_sum[ACC_WIDTH]) begin
                    result = '1;
                    flag   = 1'b1;
                end else begin
                    result = acc_sum[ACC_WIDTH-1:0];
                end
                acc_next = result;
            end
            MODE_LOAD: begin
                result   = sum_ab;
                acc_next = sum_ab;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/adder_accumulator.sv
// Two-stage pipelined adder/subtractor/accumulator with valid/ready on both
// sides. Stage 1 registers the operation; stage 2 computes and registers the
// result, flag and accumulator. Ops commit in acceptance order.
module adder_accumulator
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned ACC_WIDTH = 8
) (
    input logic                clk_i,
    input logic                reset_i,
    adder_accumulator_if.slave bus
);

    stage1_t              s1_q;
    logic                 s1_valid_q;
    logic                 valid_q;
    logic                 flag_q;
    logic [ACC_WIDTH-1:0] result_q;
    logic [ACC_WIDTH-1:0] acc_q;

    logic                 advance;
    logic                 ready;

    logic [ACC_WIDTH-1:0] core_result;
    logic [ACC_WIDTH-1:0] core_acc_next;
    logic                 core_flag;

    // Upper operand bits beyond WIDTH are always zero; fold them away.
    logic                 unused_s1;

    // Handshake: output register moves when empty or drained; stage 1 can take
    // a new op when empty or when its current op moves on.
    always_comb begin
        advance = !valid_q || bus.ready_i;
        ready   = !reset_i && (!s1_valid_q || advance);
    end

    assign bus.ready_o = ready;
    assign bus.valid_o = valid_q;
    assign bus.result  = result_q;
    assign bus.flag_o  = flag_q;
    assign unused_s1   = ^{s1_q.a, s1_q.b};

    adder_core #(
        .WIDTH     (WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_core (
        .mode     (s1_q.mode),
        .a        (s1_q.a[WIDTH-1:0]),
        .b        (s1_q.b[WIDTH-1:0]),
        .acc      (acc_q),
        .result   (core_result),
        .flag     (core_flag),
        .acc_next (core_acc_next)
    );

    // Stage 1: capture an accepted op; a stalled full stage holds its op.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
        end else if (ready) begin
            s1_valid_q <= bus.valid_i;
            if (bus.valid_i) begin
                s1_q.mode <= bus.mode_i;
                s1_q.a    <= MAX_WIDTH'(bus.number_1);
                s1_q.b    <= MAX_WIDTH'(bus.number_2);
            end
        end
    end

    // Stage 2: register result, flag and acc as the op leaves stage 1.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            flag_q   <= 1'b0;
            acc_q    <= '0;
        end else if (advance) begin
            valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                result_q <= core_result;
                flag_q   <= core_flag;
                acc_q    <= core_acc_next;
            end
        end
    end

endmodule
